// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter that owns the select of a shared N:1 word mux.
// Each requester holds req high until granted. The owner keeps the grant until it asserts
// last or drops req. The next owner is then chosen without an idle cycle between grants.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   req      in   [N]        level request per requester
//   last     in   [N]        owner's final cycle of use
//   in_data  in   [N*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   grant    out  [N]        registered one-hot grant (zero when idle)
//   sel      out  [SEL_W]    registered mux select = owner index
//   busy     out             a grant is held
//   out      out  [WIDTH]    selected word when busy, else 0 (combinational)
//   timeout  out             one-cycle pulse after a forced release
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to force a release after MAX_HOLD owned cycles.
// Without it, grants are unbounded and timeout is tied low.

module mux_rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_HOLD = 16,
    localparam int unsigned SEL_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       last,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       grant,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic [WIDTH-1:0]   out,
    output logic               timeout
);

    if (N < 2) begin : g_bad_n
        $error("mux_rr_arbiter: N must be >= 2");
    end
    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("mux_rr_arbiter: MAX_HOLD must be >= 2");
    end

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e           state_q;
    logic [N-1:0]     grant_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] ptr_q;

    logic [SEL_W-1:0] ptr_next;
    logic [N-1:0]     others;
    logic [SEL_W:0]   idle_pick;   // {found, index}
    logic [SEL_W:0]   next_pick;   // {found, index}
    logic             rel_normal;
    logic             at_max;
    logic             release_now;
    logic             new_grant;

    // First set bit of r scanning start, start+1, ... modulo N. The loop runs downward so the
    // smallest offset is written last and wins.
    function automatic logic [SEL_W:0] pick(input logic [N-1:0] r, input logic [SEL_W-1:0] start);
        logic [SEL_W:0] res;
        int             pos;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= int'(N)) pos = pos - int'(N);
            if (r[pos]) res = {1'b1, SEL_W'(pos)};
        end
        return res;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        ptr_next    = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + 1'b1;
        // The owner is excluded so it cannot win back-to-back while others wait.
        others      = req & ~grant_q;
        idle_pick   = pick(req, ptr_q);
        next_pick   = pick(others, ptr_next);
        rel_normal  = last[sel_q] | ~req[sel_q];
        release_now = rel_normal | at_max;
        new_grant   = (state_q == StIdle) ? idle_pick[SEL_W] : (release_now & next_pick[SEL_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (idle_pick[SEL_W]) begin
                        state_q <= StOwned;
                        grant_q <= onehot(idle_pick[SEL_W-1:0]);
                        sel_q   <= idle_pick[SEL_W-1:0];
                    end
                end
                StOwned: begin
                    if (release_now) begin
                        ptr_q <= ptr_next;
                        if (next_pick[SEL_W]) begin
                            grant_q <= onehot(next_pick[SEL_W-1:0]);
                            sel_q   <= next_pick[SEL_W-1:0];
                        end else begin
                            state_q <= StIdle;
                            grant_q <= '0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;

    assign at_max = (state_q == StOwned) && (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Pulse only when the limit alone caused the release.
            timeout_q <= at_max & ~rel_normal;
            if (new_grant) begin
                hold_q <= '0;
            end else if ((state_q == StOwned) && !at_max) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign at_max  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = (state_q == StOwned);
    assign out   = busy ? in_data[sel_q*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, WIDTH=16, MAX_HOLD=16). Each step drives inputs,
// queues the outputs expected after the next rising edge, then pops and compares them.

module tb_mux_rr_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 16;
    localparam int MAX_HOLD = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N-1:0]       last;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       grant;
    logic [1:0]         sel;
    logic               busy;
    logic [WIDTH-1:0]   out;
    logic               timeout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] words [N];

    typedef struct {
        string            tag;
        logic [N-1:0]     grant;
        int               sel;     // -1: not checked
        logic             busy;
        logic [WIDTH-1:0] out;
        logic             timeout;
    } exp_t;

    exp_t sb[$];

    mux_rr_arbiter #(
        .N        (N),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .last    (last),
        .in_data (in_data),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .out     (out),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_next();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (grant === e.grant) else begin
            errors++;
            $error("FAIL %s grant: got %b expected %b", e.tag, grant, e.grant);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
        end
        checks++;
        assert (out === e.out) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", e.tag, out, e.out);
        end
        checks++;
        assert (timeout === e.timeout) else begin
            errors++;
            $error("FAIL %s timeout: got %b expected %b", e.tag, timeout, e.timeout);
        end
        if (e.sel >= 0) begin
            checks++;
            assert (sel === 2'(e.sel)) else begin
                errors++;
                $error("FAIL %s sel: got %0d expected %0d", e.tag, sel, e.sel);
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] l,
                        input string tag, input logic [N-1:0] eg, input int es,
                        input logic eb, input logic et);
        exp_t e;
        reset     = rst;
        req       = r;
        last      = l;
        e.tag     = tag;
        e.grant   = eg;
        e.sel     = es;
        e.busy    = eb;
        e.out     = eb ? words[es] : '0;
        e.timeout = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_next();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'hBEEF;
        words[3] = 16'h4444;
        in_data  = {words[3], words[2], words[1], words[0]};
        reset    = 1'b1;
        req      = '1;
        last     = '0;

        // Reset dominates pending requests.
        step(1'b1, 4'b1111, 4'b0000, "rst0", 4'b0000, 0, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 4'b0000, "rst1", 4'b0000, 0, 1'b0, 1'b0);

        // Single requester; release leaves ptr at 3.
        step(1'b0, 4'b0100, 4'b0000, "single_grant", 4'b0100, 2, 1'b1, 1'b0);
        step(1'b0, 4'b0100, 4'b0100, "single_release", 4'b0000, -1, 1'b0, 1'b0);

        // ptr=3 wraps past 3 to 0, then hands straight to 1.
        step(1'b0, 4'b0011, 4'b0000, "wrap_grant", 4'b0001, 0, 1'b1, 1'b0);
        step(1'b0, 4'b0011, 4'b0001, "wrap_next", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, "drop_req_idle", 4'b0000, -1, 1'b0, 1'b0);

        // Reset mid-grant (ptr=2 here, so 1 wins), then ptr restarts at 0.
        step(1'b0, 4'b0010, 4'b0000, "own1", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b1, 4'b0010, 4'b0000, "rst_mid", 4'b0000, 0, 1'b0, 1'b0);
        step(1'b0, 4'b1010, 4'b0000, "post_rst", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b1010, 4'b0010, "post_rst_next", 4'b1000, 3, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, "idle2", 4'b0000, -1, 1'b0, 1'b0);

        // Full rotation from ptr=0, two cycles per owner, no bubbles.
        step(1'b0, 4'b1111, 4'b0000, "rot0a", 4'b0001, 0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, "rot0b", 4'b0001, 0, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0001, "rot1a", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0101, "rot1b_nonowner_last", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0010, "rot2a", 4'b0100, 2, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, "rot2b", 4'b0100, 2, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0100, "rot3a", 4'b1000, 3, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b0000, "rot3b", 4'b1000, 3, 1'b1, 1'b0);
        step(1'b0, 4'b1111, 4'b1000, "rot4a", 4'b0001, 0, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0001, "rot_end", 4'b0000, -1, 1'b0, 1'b0);

        // Hold-limit behaviour from ptr=0 with owner 0 never asserting last.
        step(1'b1, 4'b0000, 4'b0000, "rst_t6", 4'b0000, 0, 1'b0, 1'b0);
        step(1'b0, 4'b0011, 4'b0000, "hold_grant", 4'b0001, 0, 1'b1, 1'b0);
`ifdef MUX_ARB_TIMEOUT_EN
        for (int i = 0; i < MAX_HOLD - 1; i++) begin
            step(1'b0, 4'b0011, 4'b0000, "hold_keep", 4'b0001, 0, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0011, 4'b0000, "forced_release", 4'b0010, 1, 1'b1, 1'b1);
        step(1'b0, 4'b0011, 4'b0000, "timeout_pulse_end", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, "hold_idle", 4'b0000, -1, 1'b0, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 4'b0011, 4'b0000, "hold_unbounded", 4'b0001, 0, 1'b1, 1'b0);
        end
        step(1'b0, 4'b0011, 4'b0001, "hold_release", 4'b0010, 1, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 4'b0000, "hold_idle", 4'b0000, -1, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
